waiz_bench_harness: RTL and testbench

Parametrised benchmark harness between board-level I/O and a fixed-point inference core (batchnorm jet-tagging class).

- Captures one input frame and issues it to the core with a start pulse.
- Measures core latency in cycles and aborts on timeout.
- Registers the score vector and computes the argmax class sequentially.
- Counts completed frames.
- Replaces the plain pass-through top level as the instrumented wrapper used for HLS-vs-manual latency comparison.

---
 rtl/waiz_bench_harness.sv | 159 +++++++++++++++
 tb/tb_waiz_bench_harness.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waiz_bench_harness.sv
// Instrumented wrapper around a fixed-point inference core: captures a frame, starts the core,
// measures its latency with a timeout, registers the scores and finds the argmax class.
module waiz_bench_harness #(
    parameter int WIDTH          = 16,
    parameter int NFRAC          = 10,
    parameter int INPUT_SIZE     = 16,
    parameter int OUTPUT_SIZE    = 5,
    parameter int LAT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32,
    localparam int IDX_W         = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_ready,
    input  logic signed [WIDTH-1:0] input_data [0:INPUT_SIZE-1],
    output logic                    busy,
    output logic                    output_ready,
    output logic signed [WIDTH-1:0] output_data [0:OUTPUT_SIZE-1],
    output logic [IDX_W-1:0]        class_idx,
    output logic [LAT_W-1:0]        latency,
    output logic                    timeout,
    output logic [CNT_W-1:0]        frame_count,
    output logic                    core_input_ready,
    output logic signed [WIDTH-1:0] core_input_data [0:INPUT_SIZE-1],
    input  logic                    core_output_ready,
    input  logic signed [WIDTH-1:0] core_output_data [0:OUTPUT_SIZE-1]
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_t;

    if (OUTPUT_SIZE < 1 || TIMEOUT_CYCLES < 1 || NFRAC >= WIDTH ||
        (LAT_W < 31 && TIMEOUT_CYCLES >= (1 << LAT_W))) begin : g_bad_param
        $error("waiz_bench_harness: illegal parameter combination");
    end

    localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(OUTPUT_SIZE - 1);

    state_t                  state;
    state_t                  state_next;
    logic [LAT_W-1:0]        lat_cnt;
    logic signed [WIDTH-1:0] best;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        arg_i;
    logic                    arg_last;
    logic                    score_gt;
    logic                    lat_expired;

    assign arg_last    = (arg_i == IDX_LAST);
    assign score_gt    = (output_data[arg_i] > best);
    assign lat_expired = (lat_cnt == LAT_LIMIT);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:   if (input_ready) state_next = S_ISSUE;
            S_ISSUE:  state_next = S_WAIT;
            S_WAIT: begin
                if (core_output_ready) begin
                    state_next = (OUTPUT_SIZE == 1) ? S_DONE : S_ARGMAX;
                end else if (lat_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_ARGMAX: if (arg_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy             = (state != S_IDLE);
        core_input_ready = (state == S_ISSUE);
        output_ready     = (state == S_DONE);
    end

    // Datapath: frame capture, latency counter, score register and sequential argmax.
    // class_idx and frame_count are loaded on the edge entering DONE so they change
    // in the same cycle that output_ready is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the register arrays are reset element by element because their zero value is architecturally visible.
            for (int k = 0; k < INPUT_SIZE; k++) core_input_data[k] <= '0;
            for (int k = 0; k < OUTPUT_SIZE; k++) output_data[k] <= '0;
            lat_cnt     <= '0;
            latency     <= '0;
            best        <= '0;
            idx         <= '0;
            arg_i       <= '0;
            class_idx   <= '0;
            frame_count <= '0;
            timeout     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (input_ready) begin
                        for (int k = 0; k < INPUT_SIZE; k++) core_input_data[k] <= input_data[k];
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_W'(1);
                end
                S_WAIT: begin
                    if (core_output_ready) begin
                        for (int k = 0; k < OUTPUT_SIZE; k++) output_data[k] <= core_output_data[k];
                        latency <= lat_cnt;
                        best    <= core_output_data[0];
                        idx     <= '0;
                        arg_i   <= IDX_W'(1);
                        if (OUTPUT_SIZE == 1) begin
                            class_idx   <= '0;
                            frame_count <= frame_count + CNT_W'(1);
                        end
                    end else if (lat_expired) begin
                        timeout <= 1'b1;
                    end else if (lat_cnt != LAT_MAX) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_ARGMAX: begin
                    // Strict compare keeps the lower index on ties.
                    if (score_gt) begin
                        best <= output_data[arg_i];
                        idx  <= arg_i;
                    end
                    arg_i <= arg_i + IDX_W'(1);
                    if (arg_last) begin
                        class_idx   <= score_gt ? arg_i : idx;
                        frame_count <= frame_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_waiz_bench_harness.sv
// Directed self-checking bench for waiz_bench_harness: scoreboard of expected frame results,
// plus timeout, reset, ignored-request, OUTPUT_SIZE=1 and counter-wrap scenarios.
module tb_waiz_bench_harness;

    localparam int W  = 16;
    localparam int IS = 16;
    localparam int OS = 5;
    localparam int TO = 8;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [31:0]       fc;
        logic [15:0]       lat;
        logic [2:0]        idx;
        logic [4:0][15:0]  sc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Shared stimulus for the main and wrap instances
    logic                in_ready;
    logic signed [W-1:0] in_data   [0:IS-1];
    logic                cor;
    logic signed [W-1:0] core_data [0:OS-1];

    logic                busy, out_ready, tmo, core_in_ready;
    logic signed [W-1:0] out_data      [0:OS-1];
    logic signed [W-1:0] core_in_data  [0:IS-1];
    logic [2:0]          cls;
    logic [15:0]         lat;
    logic [31:0]         fc;

    logic                w_busy, w_out_ready, w_tmo, w_core_in_ready;
    logic signed [W-1:0] w_out_data     [0:OS-1];
    logic signed [W-1:0] w_core_in_data [0:IS-1];
    logic [2:0]          w_cls;
    logic [15:0]         w_lat;
    logic [1:0]          w_fc;

    logic                one_ready, one_cor;
    logic signed [W-1:0] one_core_data [0:0];
    logic                o_busy, o_out_ready, o_tmo, o_core_in_ready;
    logic signed [W-1:0] o_out_data     [0:0];
    logic signed [W-1:0] o_core_in_data [0:IS-1];
    logic [0:0]          o_cls;
    logic [15:0]         o_lat;
    logic [31:0]         o_fc;

    waiz_bench_harness #(.OUTPUT_SIZE(OS), .TIMEOUT_CYCLES(TO)) u_main (
        .clk(clk), .reset(reset), .input_ready(in_ready), .input_data(in_data),
        .busy(busy), .output_ready(out_ready), .output_data(out_data), .class_idx(cls),
        .latency(lat), .timeout(tmo), .frame_count(fc), .core_input_ready(core_in_ready),
        .core_input_data(core_in_data), .core_output_ready(cor), .core_output_data(core_data)
    );

    waiz_bench_harness #(.OUTPUT_SIZE(OS), .TIMEOUT_CYCLES(TO), .CNT_W(2)) u_wrap (
        .clk(clk), .reset(reset), .input_ready(in_ready), .input_data(in_data),
        .busy(w_busy), .output_ready(w_out_ready), .output_data(w_out_data), .class_idx(w_cls),
        .latency(w_lat), .timeout(w_tmo), .frame_count(w_fc), .core_input_ready(w_core_in_ready),
        .core_input_data(w_core_in_data), .core_output_ready(cor), .core_output_data(core_data)
    );

    waiz_bench_harness #(.OUTPUT_SIZE(1), .TIMEOUT_CYCLES(TO)) u_one (
        .clk(clk), .reset(reset), .input_ready(one_ready), .input_data(in_data),
        .busy(o_busy), .output_ready(o_out_ready), .output_data(o_out_data), .class_idx(o_cls),
        .latency(o_lat), .timeout(o_tmo), .frame_count(o_fc), .core_input_ready(o_core_in_ready),
        .core_input_data(o_core_in_data), .core_output_ready(one_cor), .core_output_data(one_core_data)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cnt = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_fc = '0;
    logic [15:0] m_lat = '0;
    logic [4:0][15:0] m_sc = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (core_in_ready === 1'b1) start_cnt <= start_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int argmax(input int s[5]);
        int b = 0;
        for (int k = 1; k < 5; k++) if (s[k] > s[b]) b = k;
        return b;
    endfunction

    // Scoreboard consumer: every output_ready must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("class_idx", cls, mon_e.idx);
                check("latency", lat, mon_e.lat);
                check("frame_count", fc, mon_e.fc);
                for (int k = 0; k < OS; k++) check("output_data", $unsigned(out_data[k]), mon_e.sc[k]);
                check("wrap_ready", w_out_ready, 1);
                check("wrap_frame_count", w_fc, mon_e.fc[1:0]);
                check("wrap_class_idx", w_cls, mon_e.idx);
                check("wrap_latency", w_lat, mon_e.lat);
                check("wrap_output_data2", $unsigned(w_out_data[2]), mon_e.sc[2]);
                m_lat = mon_e.lat;
                m_sc  = mon_e.sc;
            end
        end
    end

    task automatic run_frame(input int s0, input int s1, input int s2, input int s3, input int s4,
                             input int l, input bit hold, input bit spur);
        int          s[5];
        exp_t        e;
        int          starts;
        logic [15:0] frame [IS];
        s = '{s0, s1, s2, s3, s4};
        for (int k = 0; k < IS; k++) begin
            frame[k]   = 16'($urandom);
            in_data[k] = frame[k];
        end
        exp_fc = exp_fc + 1;
        e.cyc  = 32'(cyc + l + OS + 1);
        e.fc   = exp_fc;
        e.lat  = 16'(l);
        e.idx  = 3'(argmax(s));
        for (int k = 0; k < OS; k++) e.sc[k] = 16'(s[k]);
        sb.push_back(e);
        starts   = start_cnt;
        in_ready = 1'b1;
        cor      = spur;
        for (int k = 0; k < OS; k++) core_data[k] = 16'($urandom);
        tick();
        check("issue_pulse", core_in_ready, 1);
        check("wrap_issue_pulse", w_core_in_ready, 1);
        in_ready = hold;
        for (int k = 0; k < IS; k++) in_data[k] = 16'($urandom);
        check("issue_data0", $unsigned(core_in_data[0]), frame[0]);
        check("issue_data15", $unsigned(core_in_data[IS-1]), frame[IS-1]);
        check("wrap_issue_data0", $unsigned(w_core_in_data[0]), frame[0]);
        cor = spur;
        for (int k = 1; k <= l; k++) begin
            tick();
            if (spur && k == 1) check("spurious_no_capture", $unsigned(out_data[0]), m_sc[0]);
            cor = (k == l);
            for (int j = 0; j < OS; j++) core_data[j] = (k == l) ? 16'(s[j]) : 16'($urandom);
        end
        tick();
        cor = 1'b0;
        for (int j = 0; j < OS; j++) core_data[j] = 16'($urandom);
        for (int n = 0; n < 40 && busy; n++) begin
            tick();
            if (out_ready) in_ready = 1'b0;
        end
        in_ready = 1'b0;
        check("frame_back_to_idle", busy, 0);
        check("start_pulses_per_frame", start_cnt - starts, 1);
    endtask

    initial begin
        int c;
        reset     = 1'b0;
        in_ready  = 1'b0;
        cor       = 1'b0;
        one_ready = 1'b0;
        one_cor   = 1'b0;
        one_core_data[0] = '0;
        for (int k = 0; k < IS; k++) in_data[k] = 16'($urandom);
        for (int k = 0; k < OS; k++) core_data[k] = '0;
        tick();
        tick();

        check("rst_busy", busy, 0);
        check("rst_output_ready", out_ready, 0);
        check("rst_class_idx", cls, 0);
        check("rst_latency", lat, 0);
        check("rst_timeout", tmo, 0);
        check("rst_frame_count", fc, 0);
        check("rst_core_input_ready", core_in_ready, 0);
        check("rst_core_input_data0", $unsigned(core_in_data[0]), 0);
        for (int k = 0; k < OS; k++) check("rst_output_data", $unsigned(out_data[k]), 0);
        check("rst_one_busy", o_busy, 0);
        check("rst_wrap_frame_count", w_fc, 0);
        reset = 1'b1;
        tick();

        // Basic frame: tie between index 2 and 4 resolves low
        run_frame(10, -3, 250, 7, 250, 4, 1'b0, 1'b0);
        // All-negative scores, fastest core reply
        run_frame(-5, -2, -9, -2, -100, 1, 1'b0, 1'b0);

        // Timeout with a silent core, then a late reply that must be ignored
        c = cyc;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        repeat (TO) tick();
        check("to_cycle_before", cyc - c, TO + 1);
        check("to_not_yet", tmo, 0);
        check("to_still_busy", busy, 1);
        tick();
        check("to_pulse", tmo, 1);
        check("to_wrap_pulse", w_tmo, 1);
        check("to_idle", busy, 0);
        check("to_latency_kept", lat, m_lat);
        check("to_frame_count_kept", fc, exp_fc);
        check("to_output_data_kept", $unsigned(out_data[2]), m_sc[2]);
        cor = 1'b1;
        for (int k = 0; k < OS; k++) core_data[k] = 16'($urandom);
        tick();
        cor = 1'b0;
        check("to_pulse_one_cycle", tmo, 0);
        check("late_reply_idle", busy, 0);
        check("late_reply_no_capture", $unsigned(out_data[0]), m_sc[0]);
        tick();

        // input_ready held high through a frame
        run_frame(1, 2, 3, 4, 5, 3, 1'b1, 1'b0);
        // Spurious core_output_ready in IDLE and ISSUE
        run_frame(300, 301, -400, 302, 299, 2, 1'b0, 1'b1);

        // Reset for one cycle while lat_cnt == 3
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_core_input_ready", core_in_ready, 0);
        check("midrst_latency", lat, 0);
        check("midrst_frame_count", fc, 0);
        check("midrst_class_idx", cls, 0);
        check("midrst_core_input_data0", $unsigned(core_in_data[0]), 0);
        for (int k = 0; k < OS; k++) check("midrst_output_data", $unsigned(out_data[k]), 0);
        check("midrst_wrap_frame_count", w_fc, 0);
        reset  = 1'b1;
        exp_fc = '0;
        m_lat  = '0;
        m_sc   = '0;
        tick();
        check("midrst_still_idle", busy, 0);

        // Basic frame again, then four more for the 2-bit wrap sequence 1,2,3,0,1
        run_frame(10, -3, 250, 7, 250, 4, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            run_frame(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
                      int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
                      int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(1, 7)), 1'b0, 1'b0);
        end

        // OUTPUT_SIZE = 1 instance: DONE directly after capture
        c = cyc;
        one_ready = 1'b1;
        tick();
        check("one_issue", o_core_in_ready, 1);
        check("one_issue_data0", $unsigned(o_core_in_data[0]), $unsigned(in_data[0]));
        one_ready = 1'b0;
        tick();
        tick();
        check("one_no_result_yet", o_out_ready, 0);
        one_cor = 1'b1;
        one_core_data[0] = -16'sd77;
        tick();
        one_cor = 1'b0;
        one_core_data[0] = 16'sd5;
        check("one_done_cycle", cyc - c, 2 + 1 + 1);
        check("one_output_ready", o_out_ready, 1);
        check("one_class_idx", o_cls, 0);
        check("one_latency", o_lat, 2);
        check("one_output_data", $unsigned(o_out_data[0]), 16'hFFB3);
        check("one_frame_count", o_fc, 1);
        tick();
        check("one_idle", o_busy, 0);
        check("one_pulse_one_cycle", o_out_ready, 0);
        check("one_no_timeout", o_tmo, 0);

        tick();
        check("sb_drained", sb.size(), 0);
        check("wrap_idle", w_busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
